// File: rtl/bridge_sample_reader.sv
// Bridge read initiator: fetches 16-bit PCM words into a show-ahead FIFO.
// Optional WAIT_ACK timeout enabled by BRIDGE_SAMPLE_READER_TIMEOUT_EN.
module bridge_sample_reader #(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [26:0] base_addr,
    input  logic [15:0] length_words,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [26:0] bridge_address,
    output logic [1:0]  bridge_byte_enable,
    output logic        bridge_read,
    output logic        bridge_write,
    output logic [15:0] bridge_write_data,
    input  logic        bridge_acknowledge,
    input  logic [15:0] bridge_read_data,
    output logic [15:0] sample_data,
    output logic        sample_valid,
    input  logic        sample_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, GAP} state_t;

    state_t        state;
    logic [26:0]   addr;
    logic [15:0]   remaining;
    logic          abort_pend;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic          flush;
    logic          timeout;
    logic          ack_drop;
    logic          unused_lsb;

    assign bridge_byte_enable = 2'b11;
    assign bridge_write       = 1'b0;
    assign bridge_write_data  = 16'h0;
    assign unused_lsb         = base_addr[0];

    assign sample_valid = (count != '0);
    assign sample_data  = sample_valid ? mem[rd_ptr] : 16'h0;
    assign pop          = sample_valid & sample_ready;

    // An acknowledge for an aborted transfer is consumed but its word dropped.
    assign ack_drop = (state == WAIT_ACK) && bridge_acknowledge
                      && (abort || abort_pend);
    assign push     = (state == WAIT_ACK) && bridge_acknowledge
                      && !abort && !abort_pend;
    assign flush    = ((state == ISSUE || state == GAP) && abort)
                      || ack_drop || timeout;

`ifdef BRIDGE_SAMPLE_READER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tcnt <= '0;
        end else if (state != WAIT_ACK) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign timeout = (state == WAIT_ACK) && !bridge_acknowledge
                     && (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_CYCLES;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            bridge_read    <= 1'b0;
            bridge_address <= '0;
            addr           <= '0;
            remaining      <= '0;
            abort_pend     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        addr       <= {base_addr[26:1], 1'b0};
                        remaining  <= length_words;
                        abort_pend <= 1'b0;
                        if (length_words == 16'h0) begin
                            done <= 1'b1;
                        end else begin
                            busy  <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else if (count < (AW+1)'(FIFO_DEPTH)) begin
                        bridge_read    <= 1'b1;
                        bridge_address <= addr;
                        state          <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (bridge_acknowledge) begin
                        bridge_read <= 1'b0;
                        if (ack_drop) begin
                            abort_pend <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            addr      <= addr + 27'd2;
                            remaining <= remaining - 16'd1;
                            state     <= GAP;
                        end
                    end else if (timeout) begin
                        bridge_read <= 1'b0;
                        abort_pend  <= 1'b0;
                        error       <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end
                end
                GAP: begin
                    if (abort || remaining == 16'h0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push) begin
            mem[wr_ptr] <= bridge_read_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_bridge_sample_reader.sv
// Scoreboard bench for bridge_sample_reader (FIFO_DEPTH=4).
// Timeout case runs when BRIDGE_SAMPLE_READER_TIMEOUT_EN is defined.
module tb_bridge_sample_reader;

    localparam int DEPTH = 4;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [26:0] base_addr = '0;
    logic [15:0] length_words = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [26:0] bridge_address;
    logic [1:0]  bridge_byte_enable;
    logic        bridge_read;
    logic        bridge_write;
    logic [15:0] bridge_write_data;
    logic        bridge_acknowledge = 1'b0;
    logic [15:0] bridge_read_data = 16'hDEAD;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;

    always #5 clk_clk = ~clk_clk;

    bridge_sample_reader #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset_n(reset_reset_n),
        .start(start),
        .abort(abort),
        .base_addr(base_addr),
        .length_words(length_words),
        .busy(busy),
        .done(done),
        .error(error),
        .bridge_address(bridge_address),
        .bridge_byte_enable(bridge_byte_enable),
        .bridge_read(bridge_read),
        .bridge_write(bridge_write),
        .bridge_write_data(bridge_write_data),
        .bridge_acknowledge(bridge_acknowledge),
        .bridge_read_data(bridge_read_data),
        .sample_data(sample_data),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_reads = 0;
    int done_cnt = 0;
    int last_rise = -1;
    int rise_cyc = 0;
    int ack_delay = 2;
    bit no_ack = 1'b0;
    int rcnt = 0;
    bit prev_read = 1'b0;
    logic [26:0] cur_exp = '0;
    logic [26:0] exp_addr[$];
    logic [15:0] exp_data[$];

    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [26:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    task automatic expect_words(input logic [26:0] base, input int n,
                                input bit with_data);
        logic [26:0] a;
        for (int i = 0; i < n; i++) begin
            a = base + 27'(2 * i);
            exp_addr.push_back(a);
            if (with_data) exp_data.push_back(word_of(a));
        end
    endtask

    // Bridge responder: acknowledge ack_delay cycles after read rises.
    initial forever begin
        @(posedge clk_clk);
        #1;
        if (!bridge_read) begin
            rcnt = 0;
            bridge_acknowledge = 1'b0;
            bridge_read_data = 16'hDEAD;
        end else begin
            rcnt++;
            bridge_acknowledge = !no_ack && (rcnt == ack_delay + 1);
            bridge_read_data = bridge_acknowledge ?
                               word_of(bridge_address) : 16'hDEAD;
        end
    end

    // Monitors: bus requests, sample stream, done pulses.
    always @(negedge clk_clk) begin
        if (reset_reset_n && bridge_read && !prev_read) begin
            n_reads++;
            if (last_rise >= 0) check("read_spacing", (cyc - last_rise) >= 3, 1);
            last_rise = cyc;
            rise_cyc = cyc;
            check("byte_enable", bridge_byte_enable, 2'b11);
            if (exp_addr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_read: got addr %0h want none",
                         bridge_address);
            end else begin
                cur_exp = exp_addr.pop_front();
                check("read_addr", bridge_address, cur_exp);
            end
        end else if (bridge_read) begin
            check("addr_stable", bridge_address, cur_exp);
        end
        prev_read = bridge_read;
        if (sample_valid && sample_ready) begin
            if (exp_data.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_sample: got %0h want none", sample_data);
            end else begin
                check("sample_data", sample_data, exp_data.pop_front());
            end
        end
        if (done) done_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [26:0] b, input logic [15:0] len);
        step(1);
        base_addr = b;
        length_words = len;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int i;
        for (i = 0; i < max; i++) begin
            @(negedge clk_clk);
            if (done) break;
        end
        check({name, "_done_seen"}, i < max, 1);
    endtask

    task automatic wait_read(input int max);
        int i;
        for (i = 0; i < max; i++) begin
            step(1);
            if (bridge_read) break;
        end
        check("read_seen", i < max, 1);
    endtask

    int r0;
    int d0;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_read", bridge_read, 0);
        check("rst_addr", bridge_address, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_data", sample_data, 0);
        check("rst_write", bridge_write, 0);
        check("rst_wdata", bridge_write_data, 0);
        reset_reset_n = 1'b1;
        step(2);

        // Basic 4-word fetch; a start while busy must be ignored.
        sample_ready = 1'b1;
        ack_delay = 2;
        r0 = n_reads;
        d0 = done_cnt;
        expect_words(27'h0001000, 4, 1'b1);
        pulse_start(27'h0001000, 16'd4);
        check("t1_busy", busy, 1);
        step(4);
        pulse_start(27'h0005000, 16'd2);
        wait_done(100, "t1");
        check("t1_busy_end", busy, 0);
        step(10);
        check("t1_reads", n_reads - r0, 4);
        check("t1_done_cnt", done_cnt - d0, 1);
        check("t1_drained", exp_data.size(), 0);

        // Zero length.
        r0 = n_reads;
        d0 = done_cnt;
        pulse_start(27'h0001234, 16'd0);
        check("t2_done", done, 1);
        check("t2_busy", busy, 0);
        step(1);
        check("t2_done_low", done, 0);
        step(3);
        check("t2_reads", n_reads - r0, 0);
        check("t2_done_cnt", done_cnt - d0, 1);

        // Back-pressure: FIFO fills to DEPTH then issuing stalls.
        sample_ready = 1'b0;
        r0 = n_reads;
        expect_words(27'h0002000, 10, 1'b1);
        pulse_start(27'h0002001, 16'd10);
        step(60);
        check("t3_reads_stall", n_reads - r0, 4);
        check("t3_read_low", bridge_read, 0);
        check("t3_busy", busy, 1);
        check("t3_valid", sample_valid, 1);
        check("t3_head", sample_data, 16'h1000 ^ 16'hC3A5 ^ 16'h3000);
        sample_ready = 1'b1;
        wait_done(300, "t3");
        step(10);
        check("t3_reads", n_reads - r0, 10);
        check("t3_drained", exp_data.size(), 0);

        // Address wrap at 2^27.
        exp_addr.push_back(27'h7FFFFFC);
        exp_addr.push_back(27'h7FFFFFE);
        exp_addr.push_back(27'h0000000);
        exp_addr.push_back(27'h0000002);
        exp_data.push_back(16'hFFFC ^ 16'hC3A5);
        exp_data.push_back(16'hFFFE ^ 16'hC3A5);
        exp_data.push_back(16'h0000 ^ 16'hC3A5);
        exp_data.push_back(16'h0002 ^ 16'hC3A5);
        pulse_start(27'h7FFFFFC, 16'd4);
        wait_done(100, "t4");
        step(10);
        check("t4_addr_left", exp_addr.size(), 0);
        check("t4_drained", exp_data.size(), 0);

        // Abort in WAIT_ACK with slow acknowledge.
        ack_delay = 5;
        r0 = n_reads;
        d0 = done_cnt;
        expect_words(27'h0003000, 1, 1'b0);
        pulse_start(27'h0003000, 16'd4);
        wait_read(20);
        pulse_abort();
        check("t5_read_held", bridge_read, 1);
        wait_done(20, "t5");
        check("t5_busy", busy, 0);
        check("t5_valid", sample_valid, 0);
        check("t5_read_low", bridge_read, 0);
        step(5);
        check("t5_reads", n_reads - r0, 1);
        check("t5_done_cnt", done_cnt - d0, 1);
        check("t5_valid_after", sample_valid, 0);

        // Abort while stalled with a full FIFO flushes it.
        ack_delay = 1;
        sample_ready = 1'b0;
        r0 = n_reads;
        expect_words(27'h0004000, 4, 1'b0);
        pulse_start(27'h0004000, 16'd10);
        step(40);
        check("t6_valid_full", sample_valid, 1);
        check("t6_reads", n_reads - r0, 4);
        pulse_abort();
        wait_done(5, "t6");
        check("t6_flushed", sample_valid, 0);
        check("t6_busy", busy, 0);
        step(3);
        check("t6_reads_after", n_reads - r0, 4);

        // Start and abort together in IDLE: start wins.
        sample_ready = 1'b1;
        ack_delay = 0;
        expect_words(27'h0000100, 2, 1'b1);
        step(1);
        base_addr = 27'h0000100;
        length_words = 16'd2;
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("t7_busy", busy, 1);
        wait_done(50, "t7");
        step(10);
        check("t7_drained", exp_data.size(), 0);

        // Asynchronous reset mid-transfer.
        sample_ready = 1'b0;
        ack_delay = 2;
        r0 = n_reads;
        expect_words(27'h0008000, 2, 1'b0);
        pulse_start(27'h0008000, 16'd4);
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (n_reads - r0 >= 2) break;
        end
        check("t8_two_reads", n_reads - r0, 2);
        #2;
        reset_reset_n = 1'b0;
        #1;
        check("t8_read_drop", bridge_read, 0);
        check("t8_addr_drop", bridge_address, 0);
        check("t8_fifo_empty", sample_valid, 0);
        check("t8_busy", busy, 0);
        step(2);
        reset_reset_n = 1'b1;
        step(3);
        check("t8_idle_read", bridge_read, 0);
        check("t8_idle_valid", sample_valid, 0);

`ifdef BRIDGE_SAMPLE_READER_TIMEOUT_EN
        no_ack = 1'b1;
        expect_words(27'h0006000, 1, 1'b0);
        pulse_start(27'h0006000, 16'd2);
        wait_done(40, "t9");
        check("t9_latency", cyc - rise_cyc, 8);
        check("t9_error", error, 1);
        check("t9_read_low", bridge_read, 0);
        check("t9_busy", busy, 0);
        no_ack = 1'b0;
        step(3);
        check("t9_error_sticky", error, 1);
        pulse_start(27'h0006100, 16'd0);
        check("t9_error_clr", error, 0);
`else
        check("no_timeout_error", error, 0);
`endif

        step(5);
        check("addr_queue_empty", exp_addr.size(), 0);
        check("data_queue_empty", exp_data.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bridge_sample_reader.md
Name: bridge_sample_reader

Overview:
- Initiator for the SoC external bus bridge port (bridge_*): fetches a block of 16-bit PCM words from SDRAM through the bridge.
- Streams the fetched words through an internal show-ahead FIFO to the audio output path via a valid/ready interface.
- Sits in the FPGA fabric beside mp3player_soc; software or a control FSM supplies the base address and length and pulses start.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries (power of 2, ≥4)
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for bridge_acknowledge (used only with the optional feature)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- abort  in  1  one-cycle pulse; terminates the current transfer
- base_addr  in  27  starting byte address; bit 0 ignored
- length_words  in  16  number of 16-bit words to fetch
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end (normal, abort or error)
- error  out  1  sticky timeout flag; cleared by the next accepted start
- bridge_address  out  27  bridge byte address
- bridge_byte_enable  out  2  constant 2'b11
- bridge_read  out  1  read request
- bridge_write  out  1  constant 0
- bridge_write_data  out  16  constant 0
- bridge_acknowledge  in  1  bridge completion strobe
- bridge_read_data  in  16  read data, valid with acknowledge
- sample_data  out  16  FIFO head word
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts the head word

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, error 0.
- Word i byte address = {base_addr[26:1],1'b0} + 2*i, modulo 2^27 (wraps silently).
- Start handling:
  - start is accepted only in IDLE. It latches the address and length, clears error, and sets busy.
  - start while busy is ignored.
  - start with length_words = 0: done pulses on the next cycle, busy stays 0, no bus activity.
- FSM states:
  - IDLE: wait for start.
  - ISSUE: if FIFO count (including the reserved slot) < FIFO_DEPTH, assert bridge_read with the current address, reserve a slot, go to WAIT_ACK; otherwise stay.
  - WAIT_ACK: hold bridge_read = 1 and the address stable until bridge_acknowledge = 1.
    - On acknowledge: push bridge_read_data into the FIFO, deassert bridge_read on the next edge, advance address and remaining count, go to GAP.
  - GAP: one mandatory idle cycle with bridge_read = 0. Then go to ISSUE if words remain; if none remain, go to IDLE with busy = 0 and a done pulse.
- Only one bus transaction is ever outstanding.
- Latency: acknowledge at cycle N → word visible on sample_data at N+1. Back-to-back requests are at least 3 cycles apart.
- FIFO behaviour:
  - Show-ahead; pop on sample_valid & sample_ready.
  - Push and pop in the same cycle keeps the count unchanged.
  - A push can never overflow because the slot was reserved at issue.
  - FIFO contents persist after done until drained.
- Abort:
  - In ISSUE or GAP: go to IDLE immediately.
  - In WAIT_ACK: keep bridge_read asserted until acknowledge, discard that word (no push), then go to IDLE.
  - In all cases, flush the FIFO when entering IDLE and pulse done.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Asynchronous reset mid-transfer: bus outputs drop to 0 immediately and the FIFO is emptied.

Optional Feature:
- Macro: BRIDGE_SAMPLE_READER_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_ACK.
  - If acknowledge has not arrived after TIMEOUT_CYCLES cycles, deassert bridge_read, set error = 1, flush the FIFO, pulse done, go to IDLE.
  - A late acknowledge arriving in IDLE is ignored.
- Undefined: no counter; WAIT_ACK waits indefinitely and error is tied to 0.

Test Plan:
- base_addr=0x0001000, length=4, acknowledge 2 cycles after each read, sample_ready=1 → reads at 0x1000, 0x1002, 0x1004, 0x1006; words output in order; bridge_read low ≥1 cycle between requests; one done pulse.
- length=0 → done on the cycle after start, bridge_read never asserted, busy stays 0.
- FIFO_DEPTH=4, length=10, sample_ready=0 → exactly 4 reads issued, then bridge_read stays 0; raising sample_ready resumes until 10 words have been delivered.
- base_addr=0x7FFFFFC, length=4 → addresses 0x7FFFFFC, 0x7FFFFFE, 0x0000000, 0x0000002.
- abort pulsed while in WAIT_ACK with acknowledge delayed 5 cycles → bridge_read held until acknowledge, that word not pushed, FIFO empty, done pulses, busy=0.
- With the macro defined, TIMEOUT_CYCLES=8 and acknowledge never asserted → error=1 and done pulse 8 cycles after read assertion; the next start clears error.
